// File: rtl/uio_port_arbiter.sv
// uio_port_arbiter: round-robin owner arbitration of the shared 8-bit uio pad bus between requesters A and B.
// Latency: grant registered one edge after a request seen in IDLE; TURN_CYC dead cycles between owners; din lags uio_in by 1.
// Backpressure: level requests, no queueing; ena low forces release; UIO_ARB_PREEMPT_EN adds hold-limit preemption.
module uio_port_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       dir_a,
    input  logic       dir_b,
    input  logic [7:0] dout_a,
    input  logic [7:0] dout_b,
    input  logic [7:0] uio_in,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] din,
    output logic       din_vld,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        TURN    = 2'd3
    } state_t;

    localparam logic [2:0] TURN_LIM = 3'(TURN_CYC);

    // Out-of-range parameters would break the counter widths below.
    if (HOLD_MAX < 2 || HOLD_MAX > 255 || TURN_CYC < 1 || TURN_CYC > 7) begin : g_bad_param
        $error("uio_port_arbiter: HOLD_MAX must be 2..255 and TURN_CYC 1..7");
    end

    state_t     state_q, state_d;
    logic       last_b_q, last_b_d;   // 1 = B was the most recent owner
    logic       dir_q, dir_d;         // direction latched at grant time
    logic [2:0] turn_q, turn_d;
    logic [7:0] din_q;
    logic       din_vld_q;
    logic       preempt_a;
    logic       preempt_b;
    logic       granted;

`ifdef UIO_ARB_PREEMPT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic [7:0] cnt_q, cnt_d;

    // Owner is forced off once it has held the bus HOLD_MAX cycles while the other side waits.
    assign preempt_a = (cnt_q == HOLD_LIM) && req_b;
    assign preempt_b = (cnt_q == HOLD_LIM) && req_a;

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without preemption an owner keeps the bus until it releases or ena falls.
    assign preempt_a = 1'b0;
    assign preempt_b = 1'b0;
`endif

    // Next-state logic: arbitration, release/preemption and turnaround timing.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        dir_d    = dir_q;
        turn_d   = turn_q;
`ifdef UIO_ARB_PREEMPT_EN
        cnt_d    = cnt_q;
`endif
        if (!ena) begin
            // Disable releases straight to IDLE; no turnaround needed because oe is already off.
            state_d = IDLE;
            turn_d  = 3'd0;
`ifdef UIO_ARB_PREEMPT_EN
            cnt_d   = 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // A wins a tie only if B was served last.
                    if (req_a && (!req_b || last_b_q)) begin
                        state_d  = GRANT_A;
                        last_b_d = 1'b0;
                        dir_d    = dir_a;
`ifdef UIO_ARB_PREEMPT_EN
                        cnt_d    = 8'd1;
`endif
                    end else if (req_b) begin
                        state_d  = GRANT_B;
                        last_b_d = 1'b1;
                        dir_d    = dir_b;
`ifdef UIO_ARB_PREEMPT_EN
                        cnt_d    = 8'd1;
`endif
                    end
                end
                GRANT_A: begin
                    if (!req_a || preempt_a) begin
                        state_d = TURN;
                        turn_d  = 3'd1;
`ifdef UIO_ARB_PREEMPT_EN
                        cnt_d   = 8'd0;
                    end else if (cnt_q != HOLD_LIM) begin
                        cnt_d   = cnt_q + 8'd1;
`endif
                    end
                end
                GRANT_B: begin
                    if (!req_b || preempt_b) begin
                        state_d = TURN;
                        turn_d  = 3'd1;
`ifdef UIO_ARB_PREEMPT_EN
                        cnt_d   = 8'd0;
                    end else if (cnt_q != HOLD_LIM) begin
                        cnt_d   = cnt_q + 8'd1;
`endif
                    end
                end
                TURN: begin
                    // Requests are ignored here; the next owner is picked from IDLE.
                    if (turn_q >= TURN_LIM) begin
                        state_d = IDLE;
                        turn_d  = 3'd0;
                    end else begin
                        turn_d  = turn_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointer, direction and turnaround registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            dir_q    <= 1'b0;
            turn_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            dir_q    <= dir_d;
            turn_q   <= turn_d;
        end
    end

    assign granted = (state_q == GRANT_A) || (state_q == GRANT_B);

    // Sample the pads every cycle of a sampling grant; din_vld marks the refreshed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q     <= 8'd0;
            din_vld_q <= 1'b0;
        end else if (granted && !dir_q) begin
            din_q     <= uio_in;
            din_vld_q <= 1'b1;
        end else begin
            din_vld_q <= 1'b0;
        end
    end

    // Pad drive is combinational from state so ena can kill the enables in the same cycle.
    always_comb begin
        uio_oe  = 8'h00;
        uio_out = 8'h00;
        if (granted && dir_q && ena) begin
            uio_oe  = 8'hFF;
            uio_out = (state_q == GRANT_A) ? dout_a : dout_b;
        end
    end

    assign gnt_a   = (state_q == GRANT_A);
    assign gnt_b   = (state_q == GRANT_B);
    assign busy    = (state_q != IDLE);
    assign din     = din_q;
    assign din_vld = din_vld_q;

endmodule

// File: tb/tb_uio_port_arbiter.sv
// tb_uio_port_arbiter: directed checks of grant, round-robin, preemption, sampling and ena handling.
// Latency: inputs change 1 time unit after a rising edge; outputs are read there too.
// Backpressure: none; every wait is a bounded loop.
module tb_uio_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic       dir_a = 1'b0, dir_b = 1'b0;
    logic [7:0] dout_a = 8'h00, dout_b = 8'h00, uio_in = 8'h00;
    logic       gnt_a, gnt_b, din_vld, busy;
    logic [7:0] uio_out, uio_oe, din;

    int n_pass  = 0;
    int n_total = 0;

    uio_port_arbiter #(.HOLD_MAX(4), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_a(req_a), .req_b(req_b), .dir_a(dir_a), .dir_b(dir_b),
        .dout_a(dout_a), .dout_b(dout_b), .uio_in(uio_in),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .uio_out(uio_out), .uio_oe(uio_oe),
        .din(din), .din_vld(din_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ena = 1'b1; req_a = 1'b0; req_b = 1'b0; dir_a = 1'b0; dir_b = 1'b0;
        dout_a = 8'h00; dout_b = 8'h00; uio_in = 8'h00;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        clear_inputs();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ena = 1'($urandom); req_a = 1'($urandom); req_b = 1'($urandom);
        dir_a = 1'($urandom); dir_b = 1'($urandom);
        dout_a = 8'($urandom); dout_b = 8'($urandom); uio_in = 8'($urandom);
        tick(); tick();
        n_total++; if (gnt_a !== 1'b0) $display("FAIL reset_gnt_a got %b want 0", gnt_a); else n_pass++;
        n_total++; if (gnt_b !== 1'b0) $display("FAIL reset_gnt_b got %b want 0", gnt_b); else n_pass++;
        n_total++; if (uio_oe !== 8'h00) $display("FAIL reset_uio_oe got %h want 00", uio_oe); else n_pass++;
        n_total++; if (uio_out !== 8'h00) $display("FAIL reset_uio_out got %h want 00", uio_out); else n_pass++;
        n_total++; if (din !== 8'h00) $display("FAIL reset_din got %h want 00", din); else n_pass++;
        n_total++; if (din_vld !== 1'b0) $display("FAIL reset_din_vld got %b want 0", din_vld); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_drive_grant;
        req_a = 1'b1; dir_a = 1'b1; dout_a = 8'hA5;
        tick();
        n_total++; if (gnt_a !== 1'b1) $display("FAIL drive_gnt_a got %b want 1", gnt_a); else n_pass++;
        n_total++; if (uio_oe !== 8'hFF) $display("FAIL drive_uio_oe got %h want FF", uio_oe); else n_pass++;
        n_total++; if (uio_out !== 8'hA5) $display("FAIL drive_uio_out got %h want A5", uio_out); else n_pass++;
        req_a = 1'b0;
        tick();
        n_total++; if (gnt_a !== 1'b0) $display("FAIL release_gnt_a got %b want 0", gnt_a); else n_pass++;
        n_total++; if (uio_oe !== 8'h00) $display("FAIL release_uio_oe got %h want 00", uio_oe); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL turn_busy got %b want 1", busy); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL turn_len_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_round_robin;
        reset_dut();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        n_total++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL rr_first got %b want 10", {gnt_a, gnt_b}); else n_pass++;
        req_a = 1'b0;
        tick();
        n_total++; if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL rr_turn got %b want 00", {gnt_a, gnt_b}); else n_pass++;
        tick();
        n_total++; if (gnt_b !== 1'b0) $display("FAIL rr_gap1 got %b want 0", gnt_b); else n_pass++;
        tick();
        n_total++; if (gnt_b !== 1'b1) $display("FAIL rr_b_gnt got %b want 1", gnt_b); else n_pass++;
        req_b = 1'b0;
        tick();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        n_total++; if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL rr_turn_ignores got %b want 00", {gnt_a, gnt_b}); else n_pass++;
        tick();
        n_total++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL rr_second got %b want 10", {gnt_a, gnt_b}); else n_pass++;
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_preempt;
        int a_cyc;
        int gap;
        int b_seen;
        reset_dut();
        req_a = 1'b1; dir_a = 1'b1; dout_a = 8'h5A;
        tick();
        a_cyc = gnt_a ? 1 : 0;
        req_b = 1'b1;
`ifdef UIO_ARB_PREEMPT_EN
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!gnt_a) break;
            a_cyc++;
        end
        n_total++; if (a_cyc !== 4) $display("FAIL preempt_hold got %0d want 4", a_cyc); else n_pass++;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            gap++;
            if (gnt_b) break;
        end
        n_total++; if (gnt_b !== 1'b1) $display("FAIL preempt_b_gnt got %b want 1", gnt_b); else n_pass++;
        n_total++; if (gap !== 2) $display("FAIL preempt_gap got %0d want 2", gap); else n_pass++;
`else
        b_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gnt_a) a_cyc++;
            if (gnt_b) b_seen++;
        end
        n_total++; if (a_cyc !== 13) $display("FAIL nopreempt_hold got %0d want 13", a_cyc); else n_pass++;
        n_total++; if (b_seen !== 0) $display("FAIL nopreempt_b_seen got %0d want 0", b_seen); else n_pass++;
        req_a = 1'b0;
        tick();
        n_total++; if (gnt_a !== 1'b0) $display("FAIL nopreempt_release got %b want 0", gnt_a); else n_pass++;
        tick(); tick();
        n_total++; if (gnt_b !== 1'b1) $display("FAIL nopreempt_b_gnt got %b want 1", gnt_b); else n_pass++;
`endif
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick(); tick();
        n_total++; if (busy !== 1'b0) $display("FAIL preempt_idle got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_sample_grant;
        req_b = 1'b1; dir_b = 1'b0; dout_b = 8'hEE; uio_in = 8'h3C;
        tick();
        n_total++; if (gnt_b !== 1'b1) $display("FAIL sample_gnt_b got %b want 1", gnt_b); else n_pass++;
        n_total++; if (uio_oe !== 8'h00) $display("FAIL sample_uio_oe got %h want 00", uio_oe); else n_pass++;
        n_total++; if (din_vld !== 1'b0) $display("FAIL sample_vld_early got %b want 0", din_vld); else n_pass++;
        tick();
        n_total++; if (din !== 8'h3C) $display("FAIL sample_din got %h want 3C", din); else n_pass++;
        n_total++; if (din_vld !== 1'b1) $display("FAIL sample_din_vld got %b want 1", din_vld); else n_pass++;
        dir_b = 1'b1; uio_in = 8'hC3;
        tick();
        n_total++; if (uio_oe !== 8'h00) $display("FAIL sample_dir_toggle_oe got %h want 00", uio_oe); else n_pass++;
        n_total++; if (din !== 8'hC3) $display("FAIL sample_din2 got %h want C3", din); else n_pass++;
        req_b = 1'b0; uio_in = 8'h99;
        tick();
        tick();
        n_total++; if (din_vld !== 1'b0) $display("FAIL sample_vld_off got %b want 0", din_vld); else n_pass++;
        n_total++; if (din !== 8'h99) $display("FAIL sample_din_hold got %h want 99", din); else n_pass++;
        dir_b = 1'b0;
        tick();
    endtask

    task automatic test_ena_drop;
        req_a = 1'b1; dir_a = 1'b1; dout_a = 8'hA5;
        tick();
        n_total++; if (uio_oe !== 8'hFF) $display("FAIL ena_pre_oe got %h want FF", uio_oe); else n_pass++;
        ena = 1'b0;
        #1;
        n_total++; if (uio_oe !== 8'h00) $display("FAIL ena_same_cycle_oe got %h want 00", uio_oe); else n_pass++;
        n_total++; if (uio_out !== 8'h00) $display("FAIL ena_same_cycle_out got %h want 00", uio_out); else n_pass++;
        n_total++; if (gnt_a !== 1'b1) $display("FAIL ena_gnt_held got %b want 1", gnt_a); else n_pass++;
        tick();
        n_total++; if (gnt_a !== 1'b0) $display("FAIL ena_gnt_drop got %b want 0", gnt_a); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ena_no_turn got %b want 0", busy); else n_pass++;
        tick();
        n_total++; if (gnt_a !== 1'b0) $display("FAIL ena_low_no_grant got %b want 0", gnt_a); else n_pass++;
        ena = 1'b1;
        tick();
        n_total++; if (gnt_a !== 1'b1) $display("FAIL ena_regrant got %b want 1", gnt_a); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (gnt_a !== 1'b0) $display("FAIL reset_mid_gnt got %b want 0", gnt_a); else n_pass++;
        n_total++; if (uio_oe !== 8'h00) $display("FAIL reset_mid_oe got %h want 00", uio_oe); else n_pass++;
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_drive_grant();
        test_round_robin();
        test_preempt();
        test_sample_grant();
        test_ena_drop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uio_port_arbiter.md
# uio_port_arbiter

Arbitrates the shared 8-bit bidirectional `uio` pad bus of the top-level tile between two internal requesters (A and B). Grants are round-robin and registered, and each grant carries a latched direction (drive or sample). A turnaround gap with all output enables off separates consecutive owners. The block sits directly behind the tile's `uio_in`/`uio_out`/`uio_oe` pins and is gated by the tile's `ena`.

## Interface
Parameters:
- `HOLD_MAX`, default 16: maximum grant cycles before preemption when the other requester waits; range 2..255.
- `TURN_CYC`, default 1: turnaround cycles with no grant and `uio_oe` = 0; range 1..7.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: tile enable; low forces release.
- `req_a`, `req_b` in 1: bus request, level, held for the full ownership.
- `dir_a`, `dir_b` in 1: 1 = drive pads, 0 = sample pads; latched when the grant is issued.
- `dout_a`, `dout_b` in 8: drive data.
- `uio_in` in 8: pad input path.
- `gnt_a`, `gnt_b` out 1: registered grants; never both high.
- `uio_out` out 8: pad output data.
- `uio_oe` out 8: pad enables; all-ones or all-zeros only.
- `din` out 8: registered sample of `uio_in`.
- `din_vld` out 1: `din` updated this cycle.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, GRANT_A, GRANT_B, TURN.
- **IDLE**
  - Only `req_a` high: next state GRANT_A.
  - Only `req_b` high: next state GRANT_B.
  - Both high: grant the requester not served last. The last-served pointer resets to B, so A wins first after reset.
  - On entry to GRANT, latch the grantee's `dir` into `dir_q` and set the hold counter to 1.
- **GRANT_x**
  - Counter increments each cycle and saturates at `HOLD_MAX`.
  - `req_x` low: next state TURN.
  - Preemption: counter == `HOLD_MAX` and the other requester is high: next state TURN.
  - `dir_x` changes during the grant are ignored.
- **TURN**
  - Counts `TURN_CYC` cycles, then goes to IDLE.
  - No grants during TURN; requests are ignored.
- **Pad outputs**, combinational from registered state:
  - `uio_oe` = 8'hFF when (GRANT_x and `dir_q`=1 and `ena`), else 8'h00.
  - `uio_out` = `dout_x` under the same condition, else 8'h00.
- **Input sampling**
  - In GRANT_x with `dir_q`=0, `din` <= `uio_in` every cycle, and `din_vld` is high the following cycle.
  - Otherwise `din` holds its value and `din_vld` is 0.
- **`ena` low**
  - Next state IDLE from any state, skipping TURN; counter cleared.
  - `uio_oe` forced to 0 in the same cycle.
- **Simultaneous events**
  - Owner drops its request while the other asserts in the same cycle: TURN first, then the other is granted.
  - Preemption and release in the same cycle: a single TURN.
- **Reset:** asynchronous; every output is 0 and the state is IDLE, pointer = B, counter = 0. Reset mid-grant drops `gnt` and `uio_oe` immediately.

## Timing
- Request to grant: `req` sampled high in IDLE at edge k, `gnt` high after edge k.
- Release: `req` low sampled at edge k, `gnt` low after edge k.
- Owner-to-owner gap: `gnt` of the next owner rises `TURN_CYC`+1 cycles after the previous `gnt` falls. This is 2 cycles at the default `TURN_CYC`.
- Under continuous contention, a preempted grant is high for exactly `HOLD_MAX` cycles.
- `din` lags `uio_in` by 1 cycle; `din_vld` is aligned with `din`.

## Configuration
- `UIO_ARB_PREEMPT_EN` defined: hold counter and preemption are present as described.
- Undefined:
  - No counter is built and `HOLD_MAX` is ignored.
  - A grant is held until its owner drops `req` or `ena` falls.
  - All other behaviour is unchanged.

## Test plan
- **Reset:** `rst_n`=0 with random inputs -> `gnt_a`=`gnt_b`=0, `uio_oe`=00, `uio_out`=00, `din`=00, `din_vld`=0, `busy`=0.
- **Drive grant:** `req_a`=1, `dir_a`=1, `dout_a`=A5 -> `gnt_a`=1 one cycle later, with `uio_oe`=FF and `uio_out`=A5. Drop `req_a` -> `gnt_a`=0 and `uio_oe`=00 the next cycle; `busy` stays 1 for 1 TURN cycle.
- **Round-robin:** `req_a`=`req_b`=1 out of reset -> A granted first. A releases -> `gnt_b` rises 2 cycles after `gnt_a` falls. Both then re-request -> A granted again.
- **Preemption:** `HOLD_MAX`=4 with macro defined; A holds `req`, B requests -> `gnt_a` high exactly 4 cycles, then B granted 2 cycles later. Same stimulus without the macro -> `gnt_a` stays high until `req_a` drops.
- **Sample grant:** `req_b`=1, `dir_b`=0, `uio_in`=3C -> `uio_oe`=00; `din`=3C with `din_vld`=1 one cycle after sampling. Toggle `dir_b` mid-grant -> `uio_oe` stays 00.
- **`ena` drop:** `ena`=0 mid drive-grant -> `uio_oe`=00 in the same cycle; `gnt`=0 and `busy`=0 after the next edge, with no TURN.
